// File: rtl/axis_pkt_arb_2to1_pkg.sv
// Shared definitions for the two-source packet arbiter: frame delimiters,
// FSM state encoding and one-hot grant encodings (also used by the frame parser).
package axis_pkt_arb_2to1_pkg;

  localparam logic [15:0] SOP_WORD_C = 16'h0a0a;
  localparam logic [15:0] EOP_WORD_C = 16'h0b0b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  typedef logic [1:0] grant_t;

  localparam grant_t GNT_NONE = 2'b00;
  localparam grant_t GNT_S0   = 2'b01;
  localparam grant_t GNT_S1   = 2'b10;

endpackage

// File: rtl/axis_pkt_arb_2to1_if.sv
// AXI-Stream bundle used for both source ports and the shared master port.
interface axis_pkt_arb_2to1_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic [1:0]            tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_pkt_arb_2to1_rr_arb2.sv
// Two-request round-robin picker. Produces a one-hot grant only while enabled;
// the last winner is remembered so a tie goes to the other source next time.
module axis_pkt_arb_2to1_rr_arb2
  import axis_pkt_arb_2to1_pkg::*;
(
  input  logic   clk,
  input  logic   resetn,
  input  logic   en,
  input  grant_t req,
  output grant_t gnt
);

  grant_t last_grant;

  always_comb begin
    gnt = GNT_NONE;
    if (en) begin
      case (req)
        2'b01:   gnt = GNT_S0;
        2'b10:   gnt = GNT_S1;
        2'b11:   gnt = (last_grant == GNT_S1) ? GNT_S0 : GNT_S1;
        default: gnt = GNT_NONE;
      endcase
    end
  end

  // Reset to source 1 so that source 0 wins the very first tie.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant <= GNT_S1;
    end else if (gnt != GNT_NONE) begin
      last_grant <= gnt;
    end
  end

endmodule

// File: rtl/axis_pkt_arb_2to1.sv
// Packet-granular 2:1 AXI-Stream arbiter: holds a grant for a whole frame,
// forwards good frames with zero latency and sinks/counts frames with a bad SOP.
module axis_pkt_arb_2to1
  import axis_pkt_arb_2to1_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] SOP_WORD   = SOP_WORD_C,
  parameter int                    CNT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  axis_pkt_arb_2to1_if.slave     s0,
  axis_pkt_arb_2to1_if.slave     s1,
  axis_pkt_arb_2to1_if.master    m,
  input  logic [1:0]             port_en,
  output grant_t                 grant,
  output logic [CNT_WIDTH-1:0]   drop_cnt
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                 state, state_n;
  grant_t                 grant_n, pick;
  logic                   first_beat, first_n;
  logic [CNT_WIDTH-1:0]   drop_n;

  logic [DATA_WIDTH-1:0]  sel_data;
  logic [1:0]             sel_keep;
  logic                   sel_valid, sel_last, sel_ready;
  logic                   bad_first;

  axis_pkt_arb_2to1_rr_arb2 u_rr (
    .clk    (clk),
    .resetn (resetn),
    .en     (state == ST_IDLE),
    .req    ({s1.tvalid & port_en[1], s0.tvalid & port_en[0]}),
    .gnt    (pick)
  );

  // Granted-source mux; everything reads zero when nobody owns the port.
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    case (grant)
      GNT_S0: begin
        sel_data  = s0.tdata;
        sel_keep  = s0.tkeep;
        sel_valid = s0.tvalid;
        sel_last  = s0.tlast;
      end
      GNT_S1: begin
        sel_data  = s1.tdata;
        sel_keep  = s1.tkeep;
        sel_valid = s1.tvalid;
        sel_last  = s1.tlast;
      end
      default: ;
    endcase
  end

  assign bad_first = first_beat && (sel_data != SOP_WORD);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      grant      <= GNT_NONE;
      first_beat <= 1'b1;
      drop_cnt   <= '0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      first_beat <= first_n;
      drop_cnt   <= drop_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    first_n = first_beat;
    drop_n  = drop_cnt;
    case (state)
      ST_IDLE: begin
        if (pick != GNT_NONE) begin
          grant_n = pick;
          first_n = 1'b1;
          state_n = ST_PASS;
        end
      end
      ST_PASS: begin
        if (bad_first) begin
          // Bad first beat is always consumed; a lone-beat frame ends here.
          if (sel_valid) begin
            first_n = 1'b0;
            if (sel_last) begin
              drop_n  = sat_inc(drop_cnt);
              grant_n = GNT_NONE;
              state_n = ST_IDLE;
            end else begin
              state_n = ST_DROP;
            end
          end
        end else if (sel_valid && m.tready) begin
          first_n = 1'b0;
          if (sel_last) begin
            grant_n = GNT_NONE;
            state_n = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (sel_valid && sel_last) begin
          drop_n  = sat_inc(drop_cnt);
          grant_n = GNT_NONE;
          state_n = ST_IDLE;
        end
      end
      default: begin
        grant_n = GNT_NONE;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    m.tdata   = sel_data;
    m.tkeep   = sel_keep;
    m.tlast   = sel_last;
    m.tvalid  = 1'b0;
    sel_ready = 1'b0;
    case (state)
      ST_PASS: begin
        if (bad_first) begin
          sel_ready = 1'b1;
        end else begin
          m.tvalid  = sel_valid;
          sel_ready = m.tready;
        end
      end
      ST_DROP: sel_ready = 1'b1;
      default: ;
    endcase
    s0.tready = (grant == GNT_S0) && sel_ready;
    s1.tready = (grant == GNT_S1) && sel_ready;
  end

endmodule
